plru_tree_array: RTL and testbench

- Per-set tree pseudo-LRU replacement table for a set-associative cache.
- Generalises the 2/4-way single-set PLRU to any power-of-two associativity and any number of sets.
- Adds invalid-way priority, per-set state invalidation, and same-cycle update-to-query bypass.
- Sits beside the tag/data arrays in the I/D-cache controller. The cache FSM queries a victim on a miss and reports hits and refills as updates.

---
 rtl/plru_if.sv | 28 ++
 rtl/plru_tree_array.sv | 103 ++++++++++
 tb/tb_plru_tree_array.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plru_if.sv
// Replacement-table port bundle: the cache FSM drives accesses/queries (master),
// the PLRU table returns the victim (slave).
interface plru_if #(
  parameter int ASSOC_NUM = 4,
  parameter int SET_NUM   = 256
);
  localparam int WAY_W = $clog2(ASSOC_NUM);
  localparam int SET_W = (SET_NUM > 1) ? $clog2(SET_NUM) : 1;

  logic                 upd_valid;
  logic [SET_W-1:0]     upd_set;
  logic [ASSOC_NUM-1:0] upd_way_oh;
  logic                 inv_valid;
  logic [SET_W-1:0]     inv_set;
  logic [SET_W-1:0]     query_set;
  logic [ASSOC_NUM-1:0] way_valid;
  logic [WAY_W-1:0]     victim;
  logic [ASSOC_NUM-1:0] victim_oh;

  modport master (
    output upd_valid, upd_set, upd_way_oh, inv_valid, inv_set, query_set, way_valid,
    input  victim, victim_oh
  );
  modport slave (
    input  upd_valid, upd_set, upd_way_oh, inv_valid, inv_set, query_set, way_valid,
    output victim, victim_oh
  );
endinterface

// File: rtl/plru_tree_array.sv
// Per-set tree pseudo-LRU table: heap-ordered node bits per set, invalid-way
// priority, and same-cycle bypass of update/invalidate into the victim query.
module plru_tree_array #(
  parameter int ASSOC_NUM = 4,
  parameter int SET_NUM   = 256
) (
  input logic  clk,
  input logic  resetn,
  plru_if.slave bus
);
  localparam int WAY_W = $clog2(ASSOC_NUM);
  localparam int SET_W = (SET_NUM > 1) ? $clog2(SET_NUM) : 1;
  localparam int NODES = ASSOC_NUM - 1;
  // With a single set the index ports collapse to entry 0.
  localparam logic [SET_W-1:0] SET_MASK = SET_W'(SET_NUM - 1);

  typedef logic [NODES-1:0] tree_t;

  tree_t state [SET_NUM];

  logic [SET_W-1:0] u_set, i_set, q_set;
  assign u_set = bus.upd_set   & SET_MASK;
  assign i_set = bus.inv_set   & SET_MASK;
  assign q_set = bus.query_set & SET_MASK;

  // Point every node on the accessed way's path away from it.
  function automatic tree_t touch(tree_t t, logic [WAY_W-1:0] way);
    int node;
    logic b;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = way[WAY_W-1-l];
      for (int n = 0; n < NODES; n++)
        if (n == node) t[n] = ~b;
      node = 2 * node + 1 + int'(b);
    end
    return t;
  endfunction

  function automatic logic [WAY_W-1:0] walk(tree_t t);
    int node;
    logic b;
    logic [WAY_W-1:0] v;
    node = 0;
    v    = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int n = 0; n < NODES; n++)
        if (n == node) b = t[n];
      v[WAY_W-1-l] = b;
      node = 2 * node + 1 + int'(b);
    end
    return v;
  endfunction

  logic             upd_hit;
  logic [WAY_W-1:0] upd_way;
  always_comb begin
    upd_hit = 1'b0;
    upd_way = '0;
    for (int w = ASSOC_NUM - 1; w >= 0; w--)
      if (bus.upd_way_oh[w]) begin
        upd_hit = 1'b1;
        upd_way = WAY_W'(w);
      end
  end

  logic upd_en;
  assign upd_en = bus.upd_valid & upd_hit;

  tree_t upd_next, q_tree;
  always_comb begin
    upd_next = touch((bus.inv_valid && i_set == u_set) ? tree_t'(0) : state[u_set], upd_way);
    q_tree   = state[q_set];
    if (bus.inv_valid && i_set == q_set) q_tree = '0;
    if (upd_en && u_set == q_set)        q_tree = upd_next;
  end

  logic             any_inv;
  logic [WAY_W-1:0] first_inv;
  always_comb begin
    any_inv   = 1'b0;
    first_inv = '0;
    for (int w = ASSOC_NUM - 1; w >= 0; w--)
      if (!bus.way_valid[w]) begin
        any_inv   = 1'b1;
        first_inv = WAY_W'(w);
      end
  end

  assign bus.victim    = any_inv ? first_inv : walk(q_tree);
  assign bus.victim_oh = ASSOC_NUM'(1) << bus.victim;

  // The update write is ordered after the clear so inv+upd on one set composes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int s = 0; s < SET_NUM; s++) state[s] <= '0;
    end else begin
      if (bus.inv_valid) state[i_set] <= '0;
      if (upd_en)        state[u_set] <= upd_next;
    end
  end
endmodule

// File: tb/tb_plru_tree_array.sv
// Bench for plru_tree_array: a 4-way/16-set and an 8-way/4-set instance checked
// against a recency-timestamp model of tree PLRU.
module tb_plru_tree_array;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  plru_if #(.ASSOC_NUM(4), .SET_NUM(16)) b4();
  plru_if #(.ASSOC_NUM(8), .SET_NUM(4))  b8();

  plru_tree_array #(.ASSOC_NUM(4), .SET_NUM(16)) dut4 (.clk(clk), .resetn(resetn), .bus(b4));
  plru_tree_array #(.ASSOC_NUM(8), .SET_NUM(4))  dut8 (.clk(clk), .resetn(resetn), .bus(b8));

  int nerr = 0;
  int nchk = 0;

  // Model: per way, the time of its latest access since the set was cleared
  // (0 = none). Each tree node points away from the half holding the most
  // recent access in its subtree, or to the lower half if neither was touched.
  int unsigned ts [2][16][8];
  int unsigned tnow = 0;

  function automatic void mclr(int d, int s);
    for (int w = 0; w < 8; w++) ts[d][s][w] = 0;
  endfunction

  function automatic void mclr_all();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 16; s++) mclr(d, s);
  endfunction

  function automatic int mvict(int d, int s, logic [7:0] vv);
    int n, lo, half;
    int unsigned ml, mu;
    n = (d == 0) ? 4 : 8;
    for (int w = 0; w < n; w++) if (!vv[w]) return w;
    lo = 0;
    for (int size = n; size > 1; size = size / 2) begin
      half = size / 2;
      ml = 0;
      mu = 0;
      for (int k = 0; k < half; k++) begin
        if (ts[d][s][lo+k] > ml)      ml = ts[d][s][lo+k];
        if (ts[d][s][lo+half+k] > mu) mu = ts[d][s][lo+half+k];
      end
      if (ml > mu) lo += half;
    end
    return lo;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs and advance the model to the post-edge state.
  task automatic set4(input logic uv, input int us, input int uw, input logic iv,
                      input int is, input int qs, input logic [3:0] vv);
    b4.upd_valid  = uv;
    b4.upd_set    = 4'(us);
    b4.upd_way_oh = (uw < 0) ? 4'b0 : 4'(1 << uw);
    b4.inv_valid  = iv;
    b4.inv_set    = 4'(is);
    b4.query_set  = 4'(qs);
    b4.way_valid  = vv;
    if (iv) mclr(0, is);
    if (uv && uw >= 0) begin tnow++; ts[0][us][uw] = tnow; end
  endtask

  task automatic set8(input logic uv, input int us, input int uw, input int qs,
                      input logic [7:0] vv);
    b8.upd_valid  = uv;
    b8.upd_set    = 2'(us);
    b8.upd_way_oh = (uw < 0) ? 8'b0 : 8'(1 << uw);
    b8.inv_valid  = 1'b0;
    b8.inv_set    = 2'd0;
    b8.query_set  = 2'(qs);
    b8.way_valid  = vv;
    if (uv && uw >= 0) begin tnow++; ts[1][us][uw] = tnow; end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    set4(0, 0, -1, 0, 0, 5, 4'hF);
    set8(0, 0, -1, 0, 8'hFF);
    cyc();
    resetn = 1'b1;
    mclr_all();
    #2;
    nchk++;
    if (b4.victim !== 2'd0) begin nerr++; $display("FAIL reset_victim4: got %0d want 0", b4.victim); end
    nchk++;
    if (b4.victim_oh !== 4'b0001) begin nerr++; $display("FAIL reset_oh4: got %b want 0001", b4.victim_oh); end
    nchk++;
    if (b8.victim !== 3'd0) begin nerr++; $display("FAIL reset_victim8: got %0d want 0", b8.victim); end
  endtask

  task automatic test_seq4();
    int ways [3] = '{0, 2, 1};
    int exps [3] = '{2, 1, 3};
    for (int i = 0; i < 3; i++) begin
      set4(1, 5, ways[i], 0, 0, 6, 4'hF);
      #2;
      nchk++;
      if (b4.victim !== 2'd0) begin nerr++; $display("FAIL isolate_set6_%0d: got %0d want 0", i, b4.victim); end
      cyc();
      set4(0, 0, -1, 0, 0, 5, 4'hF);
      #2;
      nchk++;
      if (b4.victim !== 2'(exps[i]) || int'(b4.victim) != mvict(0, 5, 8'hFF)) begin
        nerr++; $display("FAIL seq4_step%0d: got %0d want %0d", i, b4.victim, exps[i]);
      end
      nchk++;
      if (b4.victim_oh !== 4'(1 << exps[i])) begin
        nerr++; $display("FAIL seq4_oh%0d: got %b want %0d-hot", i, b4.victim_oh, exps[i]);
      end
    end
  endtask

  task automatic test_assoc8();
    for (int w = 0; w < 8; w++) begin
      set8(1, 0, w, 0, 8'hFF);
      cyc();
      set8(0, 0, -1, 0, 8'hFF);
      #2;
      nchk++;
      if (int'(b8.victim) == w || int'(b8.victim) != mvict(1, 0, 8'hFF)) begin
        nerr++; $display("FAIL a8_up_w%0d: got %0d want %0d", w, b8.victim, mvict(1, 0, 8'hFF));
      end
    end
    nchk++;
    if (b8.victim !== 3'd0) begin nerr++; $display("FAIL a8_up_final: got %0d want 0", b8.victim); end
    for (int w = 7; w >= 0; w--) begin
      set8(1, 0, w, 0, 8'hFF);
      cyc();
      set8(0, 0, -1, 0, 8'hFF);
      #2;
      nchk++;
      if (int'(b8.victim) == w || int'(b8.victim) != mvict(1, 0, 8'hFF)) begin
        nerr++; $display("FAIL a8_dn_w%0d: got %0d want %0d", w, b8.victim, mvict(1, 0, 8'hFF));
      end
    end
    nchk++;
    if (b8.victim !== 3'd7) begin nerr++; $display("FAIL a8_dn_final: got %0d want 7", b8.victim); end
  endtask

  task automatic test_valid();
    logic [3:0] vv;
    int ways [3] = '{0, 2, 1};
    for (int i = 0; i < 3; i++) begin set4(1, 7, ways[i], 0, 0, 7, 4'hF); cyc(); end
    set4(0, 0, -1, 0, 0, 7, 4'hF);
    #2;
    nchk++;
    if (b4.victim !== 2'd3) begin nerr++; $display("FAIL valid_tree: got %0d want 3", b4.victim); end
    set4(0, 0, -1, 0, 0, 7, 4'b1011);
    #2;
    nchk++;
    if (b4.victim !== 2'd2) begin nerr++; $display("FAIL valid_1011: got %0d want 2", b4.victim); end
    set4(0, 0, -1, 0, 0, 7, 4'b0000);
    #2;
    nchk++;
    if (b4.victim !== 2'd0 || b4.victim_oh !== 4'b0001) begin
      nerr++; $display("FAIL valid_0000: got %0d/%b want 0/0001", b4.victim, b4.victim_oh);
    end
    for (int i = 0; i < 8; i++) begin
      vv = 4'($urandom);
      set4(0, 0, -1, 0, 0, 7, vv);
      #2;
      nchk++;
      if (int'(b4.victim) != mvict(0, 7, {4'hF, vv})) begin
        nerr++; $display("FAIL valid_rand vv=%b: got %0d want %0d", vv, b4.victim, mvict(0, 7, {4'hF, vv}));
      end
    end
  endtask

  task automatic test_bypass();
    set4(1, 3, 0, 0, 0, 3, 4'hF);
    #2;
    nchk++;
    if (b4.victim !== 2'd2) begin nerr++; $display("FAIL bypass_upd: got %0d want 2", b4.victim); end
    cyc();
    set4(0, 0, -1, 0, 0, 3, 4'hF);
    #2;
    nchk++;
    if (b4.victim !== 2'd2) begin nerr++; $display("FAIL bypass_stored: got %0d want 2", b4.victim); end
    set4(0, 0, -1, 1, 3, 3, 4'hF);
    #2;
    nchk++;
    if (b4.victim !== 2'd0) begin nerr++; $display("FAIL bypass_inv: got %0d want 0", b4.victim); end
    cyc();
  endtask

  task automatic test_inv_upd();
    set4(1, 3, 0, 0, 0, 3, 4'hF);
    cyc();
    set4(1, 3, 3, 1, 3, 3, 4'hF);
    #2;
    nchk++;
    if (b4.victim !== 2'd0) begin nerr++; $display("FAIL invupd_same_byp: got %0d want 0", b4.victim); end
    cyc();
    set4(0, 0, -1, 0, 0, 3, 4'hF);
    #2;
    nchk++;
    if (b4.victim !== 2'd0) begin nerr++; $display("FAIL invupd_same: got %0d want 0", b4.victim); end
    set4(1, 9, 0, 0, 0, 9, 4'hF);
    cyc();
    set4(1, 10, 0, 1, 9, 9, 4'hF);
    cyc();
    set4(0, 0, -1, 0, 0, 9, 4'hF);
    #2;
    nchk++;
    if (b4.victim !== 2'd0) begin nerr++; $display("FAIL invupd_diff_inv: got %0d want 0", b4.victim); end
    set4(0, 0, -1, 0, 0, 10, 4'hF);
    #2;
    nchk++;
    if (b4.victim !== 2'd2) begin nerr++; $display("FAIL invupd_diff_upd: got %0d want 2", b4.victim); end
  endtask

  task automatic test_random();
    int us, uw, is, qs, exp;
    logic uv, iv;
    logic [3:0] vv;
    for (int i = 0; i < 400; i++) begin
      uv = 1'($urandom);
      us = $urandom_range(15);
      uw = ($urandom_range(4) == 0) ? -1 : $urandom_range(3);
      iv = ($urandom_range(5) == 0);
      is = ($urandom_range(2) == 0) ? us : $urandom_range(15);
      qs = ($urandom_range(1) == 0) ? us : $urandom_range(15);
      vv = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
      set4(uv, us, uw, iv, is, qs, vv);
      exp = mvict(0, qs, {4'hF, vv});
      #2;
      nchk++;
      if (int'(b4.victim) != exp || b4.victim_oh !== 4'(1 << exp)) begin
        nerr++; $display("FAIL rand_%0d q=%0d: got %0d/%b want %0d", i, qs, b4.victim, b4.victim_oh, exp);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 10; i++) begin
      set4(1, $urandom_range(15), $urandom_range(3), 0, 0, 0, 4'hF);
      set8(1, $urandom_range(3), $urandom_range(7), 0, 8'hFF);
      cyc();
    end
    resetn = 1'b0;
    set4(1, 2, 1, 0, 0, 2, 4'hF);
    set8(1, 1, 3, 1, 8'hFF);
    cyc();
    resetn = 1'b1;
    mclr_all();
    set8(0, 0, -1, 0, 8'hFF);
    for (int s = 0; s < 16; s++) begin
      set4(0, 0, -1, 0, 0, s, 4'hF);
      #2;
      nchk++;
      if (b4.victim !== 2'd0) begin nerr++; $display("FAIL rstmid4_set%0d: got %0d want 0", s, b4.victim); end
    end
    for (int s = 0; s < 4; s++) begin
      set8(0, 0, -1, s, 8'hFF);
      #2;
      nchk++;
      if (b8.victim !== 3'd0) begin nerr++; $display("FAIL rstmid8_set%0d: got %0d want 0", s, b8.victim); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    test_reset();
    test_seq4();
    test_assoc8();
    test_valid();
    test_bypass();
    test_inv_upd();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
